fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the instruction register.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Presents the fetched instruction and its address with a valid strobe; instr_valid drives the instruction register's write enable.
- Honours downstream stall and branch/jump redirects.

---
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake and
// presents them to the instruction register. Define FETCH_MISALIGN_CHK_EN to trap misaligned redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr_out,
    output logic [31:0] addr_out,
    output logic        instr_valid,
    output logic        fault
);

`ifdef FETCH_MISALIGN_CHK_EN
    typedef enum logic [1:0] {BOOT, REQ, VALID, HALT} fetchState_t;
`else
    typedef enum logic [1:0] {BOOT, REQ, VALID} fetchState_t;
`endif

    fetchState_t state, stateNext;
    logic [31:0] pc, pcNext;
    logic [31:0] pendPc, pendPcNext;
    logic        squash, squashNext;
    logic        imemReq, reqNext;
    logic [31:0] instrReg, instrNext;
    logic [31:0] addrReg, addrNext;
    logic        validReg, validNext;
    logic [31:0] targetPc;
    logic        ackSeen;

`ifdef FETCH_MISALIGN_CHK_EN
    logic faultReg, faultNext;
    logic misaligned;
    assign targetPc   = redirect_pc;
    assign misaligned = |redirect_pc[1:0];
`else
    assign targetPc   = redirect_pc & ~32'd3;
`endif

    // An ack with no request on the bus is spurious and must not move the stream.
    assign ackSeen = imem_ack && imemReq;

    // NOTE: every next-value defaults to its current value first, so no branch
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        stateNext  = state;
        pcNext     = pc;
        pendPcNext = pendPc;
        squashNext = squash;
        reqNext    = imemReq;
        instrNext  = instrReg;
        addrNext   = addrReg;
        validNext  = validReg;
`ifdef FETCH_MISALIGN_CHK_EN
        faultNext  = faultReg;
`endif
        case (state)
            BOOT: begin
                stateNext = REQ;
                reqNext   = 1'b1;
                if (redirect) pcNext = targetPc;
            end
            REQ: begin
                if (redirect) begin
                    if (ackSeen) begin
                        pcNext     = targetPc;
                        squashNext = 1'b0;
                    end else if (imemReq) begin
                        // The handshake in flight must complete; remember where to go afterwards.
                        pendPcNext = targetPc;
                        squashNext = 1'b1;
                    end else begin
                        pcNext  = targetPc;
                        reqNext = 1'b1;
                    end
                end else if (ackSeen) begin
                    if (squash) begin
                        pcNext     = pendPc;
                        squashNext = 1'b0;
                    end else begin
                        instrNext = imem_data;
                        addrNext  = pc;
                        pcNext    = pc + PC_INC;
                        validNext = 1'b1;
                        reqNext   = 1'b0;
                        stateNext = VALID;
                    end
                end
            end
            VALID: begin
                if (redirect) begin
                    pcNext    = targetPc;
                    validNext = 1'b0;
                    reqNext   = 1'b1;
                    stateNext = REQ;
                end else if (!stall) begin
                    validNext = 1'b0;
                    reqNext   = 1'b1;
                    stateNext = REQ;
                end
            end
`ifdef FETCH_MISALIGN_CHK_EN
            HALT: begin
                reqNext   = 1'b0;
                validNext = 1'b0;
            end
`endif
            default: stateNext = BOOT;
        endcase

`ifdef FETCH_MISALIGN_CHK_EN
        // A misaligned target halts the stream wherever it is sampled, even under squash.
        if (state != HALT && redirect && misaligned) begin
            stateNext  = HALT;
            reqNext    = 1'b0;
            validNext  = 1'b0;
            squashNext = 1'b0;
            faultNext  = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values produced by the combinational block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            pendPc   <= 32'h0;
            squash   <= 1'b0;
            imemReq  <= 1'b0;
            instrReg <= 32'h0;
            addrReg  <= 32'h0;
            validReg <= 1'b0;
        end else begin
            state    <= stateNext;
            pc       <= pcNext;
            pendPc   <= pendPcNext;
            squash   <= squashNext;
            imemReq  <= reqNext;
            instrReg <= instrNext;
            addrReg  <= addrNext;
            validReg <= validNext;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) faultReg <= 1'b0;
        else      faultReg <= faultNext;
    end
    assign fault = faultReg;
`else
    assign fault = 1'b0;
`endif

    // The PC only moves when no request is outstanding, so it doubles as the bus address.
    assign imem_req    = imemReq;
    assign imem_addr   = pc;
    assign instr_out   = instrReg;
    assign addr_out    = addrReg;
    assign instr_valid = validReg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations,
// then randomized stall/redirect/ack traffic against a fetch-stream model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr_out;
    logic [31:0] addr_out;
    logic        instr_valid;
    logic        fault;

    int nTests = 0;
    int nFail  = 0;

    // Model of the fetch stream: where the next fetch goes, what is on offer downstream.
    bit          mBoot, mReq, mValid, mSquash, mFault, mHalt;
    logic [31:0] mPc, mPend, mInstr, mAddr;

    fetch_unit #(.RESET_PC(RESET_PC), .PC_INC(PC_INC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_out(instr_out), .addr_out(addr_out), .instr_valid(instr_valid), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        if (a == 32'h0) return 32'h11;
        if (a == 32'h4) return 32'h22;
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    task automatic checkBit(input string name, input logic act, input logic exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mBoot = 1'b1; mReq = 1'b0; mValid = 1'b0; mSquash = 1'b0; mFault = 1'b0; mHalt = 1'b0;
        mPc = RESET_PC; mPend = 32'h0; mInstr = 32'h0; mAddr = 32'h0;
    endtask

    task automatic modelStep(input bit st, input bit rd, input logic [31:0] rp, input bit ak);
        bit          ackEff;
        logic [31:0] tgt;
        ackEff = ak && mReq;
        if (mHalt) return;
`ifdef FETCH_MISALIGN_CHK_EN
        tgt = rp;
        if (rd && rp[1:0] != 2'b00) begin
            mHalt = 1'b1; mFault = 1'b1; mReq = 1'b0; mValid = 1'b0; mSquash = 1'b0; mBoot = 1'b0;
            return;
        end
`else
        tgt = {rp[31:2], 2'b00};
`endif
        if (mBoot) begin
            mBoot = 1'b0;
            mReq  = 1'b1;
            if (rd) mPc = tgt;
        end else if (mReq) begin
            if (rd && ackEff) begin
                mPc = tgt; mSquash = 1'b0;
            end else if (rd) begin
                mPend = tgt; mSquash = 1'b1;
            end else if (ackEff && mSquash) begin
                mPc = mPend; mSquash = 1'b0;
            end else if (ackEff) begin
                mValid = 1'b1; mInstr = memData(mPc); mAddr = mPc;
                mPc = mPc + PC_INC; mReq = 1'b0;
            end
        end else if (rd) begin
            mPc = tgt; mValid = 1'b0; mReq = 1'b1;
        end else if (!st) begin
            mValid = 1'b0; mReq = 1'b1;
        end
    endtask

    task automatic compareAll();
        checkBit("imem_req", imem_req, mReq);
        if (mReq) checkWord("imem_addr", imem_addr, mPc);
        checkBit("instr_valid", instr_valid, mValid);
        if (mValid) begin
            checkWord("instr_out", instr_out, mInstr);
            checkWord("addr_out", addr_out, mAddr);
        end
        checkBit("fault", fault, mFault);
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance the model, compare after the edge.
    task automatic step(input bit st, input bit rd, input logic [31:0] rp, input bit ak);
        stall = st; redirect = rd; redirect_pc = rp; imem_ack = ak;
        imem_data = memData(imem_addr);
        modelStep(st, rd, rp, ak);
        @(negedge clk);
        compareAll();
    endtask

    task automatic resetPulse();
        stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
        rst = 1'b0;
        modelReset();
        @(negedge clk);
        compareAll();
        checkWord("rst_imem_addr", imem_addr, RESET_PC);
        checkWord("rst_instr_out", instr_out, 32'h0);
        checkWord("rst_addr_out", addr_out, 32'h0);
        rst = 1'b1;
    endtask

    initial begin
        #1 rst = 1'b0;
        modelReset();
        @(negedge clk);
        compareAll();
        checkBit("reset_req", imem_req, 1'b0);
        checkBit("reset_valid", instr_valid, 1'b0);
        checkWord("reset_addr", imem_addr, 32'h0);
        checkWord("reset_instr", instr_out, 32'h0);
        checkWord("reset_addr_out", addr_out, 32'h0);
        checkBit("reset_fault", fault, 1'b0);
        rst = 1'b1;

        // Back-to-back fetches with same-cycle acks.
        step(0, 0, 32'h0, 0);
        checkBit("tp1_req0", imem_req, 1'b1);
        checkWord("tp1_addr0", imem_addr, 32'h0);
        step(0, 0, 32'h0, 1);
        checkBit("tp1_valid0", instr_valid, 1'b1);
        checkWord("tp1_addr_out0", addr_out, 32'h0);
        checkWord("tp1_instr0", instr_out, 32'h11);
        step(0, 0, 32'h0, 1);
        checkBit("tp1_gap", instr_valid, 1'b0);
        checkWord("tp1_addr1", imem_addr, 32'h4);
        step(0, 0, 32'h0, 1);
        checkBit("tp1_valid1", instr_valid, 1'b1);
        checkWord("tp1_addr_out1", addr_out, 32'h4);
        checkWord("tp1_instr1", instr_out, 32'h22);

        // Stall holds the presented instruction.
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 32'h0, 1);
            checkBit("tp2_hold_valid", instr_valid, 1'b1);
            checkWord("tp2_hold_addr", addr_out, 32'h8);
            checkWord("tp2_hold_instr", instr_out, memData(32'h8));
            checkBit("tp2_hold_req", imem_req, 1'b0);
        end
        step(0, 0, 32'h0, 0);
        checkWord("tp2_next", imem_addr, 32'hC);

        // Slow ack with a redirect in the middle of the wait.
        step(0, 0, 32'h0, 0);
        checkWord("tp3_w1", imem_addr, 32'hC);
        step(0, 1, 32'h100, 0);
        checkWord("tp3_w2", imem_addr, 32'hC);
        step(0, 0, 32'h0, 0);
        checkWord("tp3_w3", imem_addr, 32'hC);
        step(0, 0, 32'h0, 0);
        checkWord("tp3_w4", imem_addr, 32'hC);
        step(0, 0, 32'h0, 1);
        checkBit("tp3_discard", instr_valid, 1'b0);
        checkBit("tp3_req", imem_req, 1'b1);
        checkWord("tp3_next", imem_addr, 32'h100);

        // Redirect coinciding with ack.
        step(0, 1, 32'h40, 1);
        checkBit("tp4_discard", instr_valid, 1'b0);
        checkWord("tp4_next", imem_addr, 32'h40);
        step(0, 0, 32'h0, 1);
        checkWord("tp4_addr_out", addr_out, 32'h40);

        // PC wrap at the top of the address space.
        step(0, 1, 32'hFFFF_FFFC, 0);
        checkWord("tp5_top", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 32'h0, 1);
        checkWord("tp5_addr_out", addr_out, 32'hFFFF_FFFC);
        step(0, 0, 32'h0, 0);
        checkWord("tp5_wrap", imem_addr, 32'h0);

`ifdef FETCH_MISALIGN_CHK_EN
        step(0, 1, 32'h102, 0);
        checkBit("tp6_fault", fault, 1'b1);
        checkBit("tp6_req", imem_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 1);
            checkBit("tp6_halt_req", imem_req, 1'b0);
            checkBit("tp6_halt_fault", fault, 1'b1);
        end
        resetPulse();
        checkBit("tp6_fault_clr", fault, 1'b0);
        step(0, 0, 32'h0, 0);
`else
        step(0, 1, 32'h102, 0);
        checkWord("tp6_held", imem_addr, 32'h0);
        checkBit("tp6_nofault", fault, 1'b0);
        step(0, 0, 32'h0, 1);
        checkWord("tp6_aligned", imem_addr, 32'h100);
`endif

        // Asynchronous reset while a request is on the bus.
        #2 rst = 1'b0;
        modelReset();
        #1;
        checkBit("async_req", imem_req, 1'b0);
        checkWord("async_addr", imem_addr, RESET_PC);
        checkBit("async_valid", instr_valid, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Redirect during the boot cycle.
        step(0, 1, 32'h200, 0);
        checkBit("boot_redir_req", imem_req, 1'b1);
        checkWord("boot_redir_addr", imem_addr, 32'h200);

        for (int i = 0; i < 3000; i++) begin
            bit          st, rd, ak;
            logic [31:0] rp;
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 9) == 0);
            ak = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            else rp = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
            if ($urandom_range(0, 49) != 0) rp = rp & ~32'd3;
`endif
            step(st, rd, rp, ak);
            if (mHalt) resetPulse();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
